backtrack_unit: RTL and testbench

// - Conflict-recovery stage of the DPLL datapath, directly downstream of trace_table's pop port.
// - On a conflict it pops trace entries one at a time and unassigns every forced (F) variable.
// - At the first decision (D) entry it flips that value and pushes it back as forced; this flip is the backtrack.
// - If the stack empties before any D entry is found, it reports UNSAT.

---
 rtl/sat_pkg.sv | 19 +
 rtl/bt_stat_counter.sv | 24 ++
 rtl/backtrack_unit.sv | 192 +++++++++++++++++++
 tb/tb_backtrack_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared SAT datapath types: variable index width, trace entry layout.
package sat_pkg;

  localparam int unsigned VAR_W = 9;

  typedef logic [VAR_W-1:0] var_idx_t;

  typedef enum logic {
    T_DECISION = 1'b0,
    T_FORCED   = 1'b1
  } trace_type_e;

  typedef struct packed {
    trace_type_e typ;
    logic        val;
    var_idx_t    vidx;
  } trace_entry_t;

endpackage

// File: rtl/bt_stat_counter.sv
// Saturating event counter used for the optional backtrack statistics.
module bt_stat_counter #(
  parameter int unsigned W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/backtrack_unit.sv
// Conflict-recovery backtrack engine: pops the trace, unassigns forced
// variables, flips the first decision found and pushes it back as forced.
// Optional statistics counters are enabled with macro BT_STATS_EN.
module backtrack_unit
  import sat_pkg::*;
#(
  parameter int unsigned NUM_VARIABLE = 128,
  parameter int unsigned VAR_W        = sat_pkg::VAR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             unsat,
  output logic             tt_pop,
  output logic             tt_push,
  output logic             tt_type,
  output logic             tt_val,
  output logic [VAR_W-1:0] tt_var,
  input  logic             tt_type_out,
  input  logic             tt_val_out,
  input  logic [VAR_W-1:0] tt_var_out,
  input  logic             tt_empty,
  input  logic             tt_done,
  output logic             va_we,
  output logic [VAR_W-1:0] va_var,
  output logic             va_assigned,
  output logic             va_val,
`ifdef BT_STATS_EN
  output logic [$clog2(NUM_VARIABLE*NUM_VARIABLE):0] stat_backtracks,
  output logic [$clog2(NUM_VARIABLE*NUM_VARIABLE):0] stat_pops,
`endif
  output logic [VAR_W-1:0] flip_var
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPopReq,
    StPopWait,
    StUnassign,
    StFlip,
    StPushWait,
    StFin
  } state_e;

  typedef struct packed {
    logic             typ;
    logic             val;
    logic [VAR_W-1:0] vidx;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           entry_q, entry_d;
  logic [VAR_W-1:0] flip_q, flip_d;
  // Selects which pulse FIN emits: 1 = unsat, 0 = done.
  logic             unsat_q, unsat_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      entry_q <= '0;
      flip_q  <= '0;
      unsat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      flip_q  <= flip_d;
      unsat_q <= unsat_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    flip_d      = flip_q;
    unsat_d     = unsat_q;
    busy        = 1'b0;
    done        = 1'b0;
    unsat       = 1'b0;
    tt_pop      = 1'b0;
    tt_push     = 1'b0;
    tt_type     = 1'b0;
    tt_val      = 1'b0;
    tt_var      = '0;
    va_we       = 1'b0;
    va_var      = '0;
    va_assigned = 1'b0;
    va_val      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        busy = 1'b1;
        if (tt_empty) begin
          unsat_d = 1'b1;
          state_d = StFin;
        end else begin
          unsat_d = 1'b0;
          state_d = StPopReq;
        end
      end
      StPopReq: begin
        busy    = 1'b1;
        tt_pop  = 1'b1;
        state_d = StPopWait;
      end
      StPopWait: begin
        busy = 1'b1;
        if (tt_done) begin
          entry_d.typ  = tt_type_out;
          entry_d.val  = tt_val_out;
          entry_d.vidx = tt_var_out;
          state_d      = StUnassign;
        end
      end
      StUnassign: begin
        busy   = 1'b1;
        va_we  = 1'b1;
        va_var = entry_q.vidx;
        if (entry_q.typ == 1'(T_FORCED)) begin
          state_d = StCheck;
        end else begin
          state_d = StFlip;
        end
      end
      StFlip: begin
        busy        = 1'b1;
        va_we       = 1'b1;
        va_assigned = 1'b1;
        va_val      = ~entry_q.val;
        va_var      = entry_q.vidx;
        tt_push     = 1'b1;
        tt_type     = 1'(T_FORCED);
        tt_val      = ~entry_q.val;
        tt_var      = entry_q.vidx;
        flip_d      = entry_q.vidx;
        state_d     = StPushWait;
      end
      StPushWait: begin
        busy = 1'b1;
        if (tt_done) begin
          unsat_d = 1'b0;
          state_d = StFin;
        end
      end
      StFin: begin
        done    = ~unsat_q;
        unsat   = unsat_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign flip_var = flip_q;

`ifdef BT_STATS_EN
  localparam int unsigned StatW = $clog2(NUM_VARIABLE * NUM_VARIABLE) + 1;

  logic pop_received;
  assign pop_received = (state_q == StPopWait) && tt_done;

  bt_stat_counter #(
    .W (StatW)
  ) u_stat_backtracks (
    .clk   (clk),
    .reset (reset),
    .inc   (done),
    .count (stat_backtracks)
  );

  bt_stat_counter #(
    .W (StatW)
  ) u_stat_pops (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_received),
    .count (stat_pops)
  );
`endif

endmodule

// File: tb/tb_backtrack_unit.sv
// Scoreboard bench for backtrack_unit with a behavioural trace_table model.
module tb_backtrack_unit;
  import sat_pkg::*;

  localparam int NV = 128;
  localparam int VW = 9;
  localparam int SW = $clog2(NV * NV) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, unsat, tt_pop, tt_push, tt_type, tt_val;
  logic [VW-1:0] tt_var;
  logic          tt_type_out = 1'b0;
  logic          tt_val_out  = 1'b0;
  logic [VW-1:0] tt_var_out  = '0;
  logic          tt_empty    = 1'b1;
  logic          tt_done     = 1'b0;
  logic          va_we, va_assigned, va_val;
  logic [VW-1:0] va_var;
  logic [VW-1:0] flip_var;
`ifdef BT_STATS_EN
  logic [SW-1:0] stat_backtracks, stat_pops;
`endif

  backtrack_unit #(
    .NUM_VARIABLE (NV),
    .VAR_W        (VW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .unsat           (unsat),
    .tt_pop          (tt_pop),
    .tt_push         (tt_push),
    .tt_type         (tt_type),
    .tt_val          (tt_val),
    .tt_var          (tt_var),
    .tt_type_out     (tt_type_out),
    .tt_val_out      (tt_val_out),
    .tt_var_out      (tt_var_out),
    .tt_empty        (tt_empty),
    .tt_done         (tt_done),
    .va_we           (va_we),
    .va_var          (va_var),
    .va_assigned     (va_assigned),
    .va_val          (va_val),
`ifdef BT_STATS_EN
    .stat_backtracks (stat_backtracks),
    .stat_pops       (stat_pops),
`endif
    .flip_var        (flip_var)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pop_count = 0;
  bit model_stall = 1'b0;
  bit inject_stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit assigned; int vidx; bit val;} va_exp_t;
  typedef struct {int vidx; bit val;} push_exp_t;
  typedef struct {bit is_unsat; int lat; int flip;} fin_exp_t;

  va_exp_t      va_q[$];
  push_exp_t    push_q[$];
  fin_exp_t     fin_q[$];
  trace_entry_t stack[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // trace_table model: requests seen mid-cycle are answered for one cycle
  // starting just after the next rising edge.
  initial begin
    bit pop_seen, push_seen, pv;
    logic [VW-1:0] pvar;
    trace_entry_t e;
    forever begin
      @(negedge clk);
      pop_seen  = tt_pop && !model_stall && !reset;
      push_seen = tt_push && !reset;
      pv        = tt_val;
      pvar      = tt_var;
      @(posedge clk);
      #1;
      tt_done = 1'b0;
      if (pop_seen && stack.size() > 0) begin
        e = stack.pop_back();
        tt_type_out = e.typ;
        tt_val_out  = e.val;
        tt_var_out  = e.vidx;
        tt_done     = 1'b1;
      end
      if (push_seen) begin
        e.typ  = T_FORCED;
        e.val  = pv;
        e.vidx = pvar;
        stack.push_back(e);
        tt_done = 1'b1;
      end
      if (inject_stray) begin
        tt_done      = 1'b1;
        inject_stray = 1'b0;
      end
      tt_empty = (stack.size() == 0);
    end
  end

  // Monitor: every DUT strobe is matched against the next queued expectation.
  always @(negedge clk) begin
    va_exp_t   ve;
    push_exp_t pe;
    fin_exp_t  fe;
    if (!reset) begin
      if (tt_pop) pop_count = pop_count + 1;
      if (tt_pop && tt_push) check("pop_push_overlap", 1, 0);
      if (va_we) begin
        if (va_q.size() == 0) check("va_unexpected", 1, 0);
        else begin
          ve = va_q.pop_front();
          check("va_assigned", int'(va_assigned), int'(ve.assigned));
          check("va_var", int'(va_var), ve.vidx);
          if (ve.assigned) check("va_val", int'(va_val), int'(ve.val));
        end
      end
      if (tt_push) begin
        if (push_q.size() == 0) check("push_unexpected", 1, 0);
        else begin
          pe = push_q.pop_front();
          check("push_type", int'(tt_type), 1);
          check("push_val", int'(tt_val), int'(pe.val));
          check("push_var", int'(tt_var), pe.vidx);
        end
      end
      if (done || unsat) begin
        if (fin_q.size() == 0) check("fin_unexpected", 1, 0);
        else begin
          fe = fin_q.pop_front();
          check("fin_kind", int'({done, unsat}), fe.is_unsat ? 1 : 2);
          check("fin_latency", cyc - start_cyc, fe.lat);
          check("flip_var", int'(flip_var), fe.flip);
        end
      end
    end
  end

  function automatic trace_entry_t ent(input bit typ, input int v, input bit val);
    ent.typ  = trace_type_e'(typ);
    ent.val  = val;
    ent.vidx = VW'(v);
  endfunction

  function automatic va_exp_t vx(input bit a, input int v, input bit val);
    vx.assigned = a;
    vx.vidx     = v;
    vx.val      = val;
  endfunction

  function automatic fin_exp_t fx(input bit u, input int lat, input int flip);
    fx.is_unsat = u;
    fx.lat      = lat;
    fx.flip     = flip;
  endfunction

  function automatic push_exp_t px(input int v, input bit val);
    px.vidx = v;
    px.val  = val;
  endfunction

  task automatic do_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] v;
    v = {busy, done, unsat, tt_pop, tt_push, tt_type, tt_val, tt_var,
         va_we, va_var, va_assigned, va_val, flip_var};
    check(name, (v == '0) ? 0 : 1, 0);
  endtask

  // Wait for the scoreboard to drain, then confirm nothing is left over.
  task automatic finish_run(input string name, input int exp_pops, input int pop_base);
    int n = 0;
    while (fin_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (fin_q.size() != 0) begin
      check({name, "_timeout"}, 1, 0);
      fin_q.delete();
    end
    repeat (2) @(negedge clk);
    check({name, "_va_left"}, va_q.size(), 0);
    check({name, "_push_left"}, push_q.size(), 0);
    check({name, "_pops"}, pop_count - pop_base, exp_pops);
    check({name, "_busy_after"}, int'(busy), 0);
    va_q.delete();
    push_q.delete();
  endtask

  task automatic run_t1();
    int base;
    stack.delete();
    stack.push_back(ent(0, 5, 1));
    va_q.push_back(vx(0, 5, 0));
    va_q.push_back(vx(1, 5, 0));
    push_q.push_back(px(5, 0));
    fin_q.push_back(fx(0, 7, 5));
    base = pop_count;
    do_start();
    finish_run("t1", 1, base);
  endtask

  task automatic run_t2(input bit extra_start);
    int base;
    stack.delete();
    stack.push_back(ent(0, 2, 0));
    stack.push_back(ent(1, 7, 1));
    stack.push_back(ent(1, 9, 0));
    va_q.push_back(vx(0, 9, 0));
    va_q.push_back(vx(0, 7, 0));
    va_q.push_back(vx(0, 2, 0));
    va_q.push_back(vx(1, 2, 1));
    push_q.push_back(px(2, 1));
    fin_q.push_back(fx(0, 15, 2));
    base = pop_count;
    do_start();
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    finish_run("t2", 3, base);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_outputs");

    run_t1();
    run_t2(1'b1);

    // Two forced entries, no decision: both unassigned, then unsat.
    stack.delete();
    stack.push_back(ent(1, 3, 1));
    stack.push_back(ent(1, 4, 0));
    va_q.push_back(vx(0, 4, 0));
    va_q.push_back(vx(0, 3, 0));
    fin_q.push_back(fx(1, 10, 2));
    base = pop_count;
    do_start();
    finish_run("t3", 2, base);

    // A stray tt_done while idle must not wake the engine.
    inject_stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_done_busy", int'(busy), 0);

    // Empty stack: CHECK then FIN, so unsat shows two cycles after the start
    // cycle (the third cycle counting the start cycle itself).
    stack.delete();
    fin_q.push_back(fx(1, 2, 2));
    base = pop_count;
    do_start();
    finish_run("t4", 0, base);

    // Reset while waiting on a pop that never answers.
    stack.delete();
    stack.push_back(ent(0, 6, 1));
    model_stall = 1'b1;
    base = pop_count;
    do_start();
    n = 0;
    while (pop_count == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_pop_seen", pop_count - base, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_outputs");
`ifdef BT_STATS_EN
    check("rst_stat_bt", int'(stat_backtracks), 0);
    check("rst_stat_pops", int'(stat_pops), 0);
`endif
    @(posedge clk);
    #1;
    stack.delete();
    model_stall = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_t2(1'b0);
    run_t1();
`ifdef BT_STATS_EN
    check("stat_backtracks", int'(stat_backtracks), 2);
    check("stat_pops", int'(stat_pops), 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
